// File: rtl/ntt_coeff_unloader_if.sv
// BRAM read-port and output-stream bundle for the NTT coefficient unloader.
// The master side is the unloader itself; the slave side is the BRAM plus the downstream consumer.
interface ntt_coeff_unloader_if #(
    parameter int WIDTH      = 16,
    parameter int WIDTH_ADDR = 8
);
    logic                   mem_en;
    logic [WIDTH_ADDR-1:0]  mem_raddr_a;
    logic [WIDTH_ADDR-1:0]  mem_raddr_b;
    logic [31:0]            mem_dout_a;
    logic [31:0]            mem_dout_b;

    logic                   m_valid;
    logic                   m_ready;
    logic [2*WIDTH-1:0]     m_data;
    logic [WIDTH_ADDR-2:0]  m_index;
    logic                   m_last;

    modport master (
        output mem_en, mem_raddr_a, mem_raddr_b,
        input  mem_dout_a, mem_dout_b,
        output m_valid, m_data, m_index, m_last,
        input  m_ready
    );

    modport slave (
        input  mem_en, mem_raddr_a, mem_raddr_b,
        output mem_dout_a, mem_dout_b,
        input  m_valid, m_data, m_index, m_last,
        output m_ready
    );
endinterface

// File: rtl/ntt_coeff_unloader.sv
// Reads all N coefficients from the dual-port BRAM, canonicalizes them to [0, Q) and streams
// coefficient pairs in natural order through a two-entry registered output buffer.
module ntt_coeff_unloader #(
    parameter int WIDTH      = 16,
    parameter int WIDTH_ADDR = 8,
    parameter int N          = 256,
    parameter int Q          = 3329,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    ntt_coeff_unloader_if.master bus
);
    localparam int              KW     = WIDTH_ADDR - 1;
    localparam logic [KW-1:0]   LAST_K = KW'(N / 2 - 1);
    localparam logic [WIDTH-1:0] QV    = WIDTH'(Q);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic                  arm_q;
    logic                  issue;
    logic [WIDTH_ADDR-1:0] addr_a_q, addr_b_q;
    logic                  inflight_q;
    logic [KW-1:0]         infl_k_q;
    logic                  infl_last_q;
    logic                  v0_q, v1_q;
    logic [2*WIDTH-1:0]    data0_q, data1_q;
    logic [KW-1:0]         idx0_q, idx1_q;
    logic                  last0_q, last1_q;
    logic                  pop, push, room;
    logic [2:0]            pending;
    logic [2*WIDTH-1:0]    push_data;
    logic                  unused_dout_hi;

    // Legal input range is [-Q, 2Q); a single conditional add/subtract brings it into [0, Q).
    function automatic logic [WIDTH-1:0] canon(input logic [WIDTH-1:0] x);
        if (x[WIDTH-1])
            return x + QV;
        else if (x >= QV)
            return x - QV;
        else
            return x;
    endfunction

    assign pop       = v0_q & bus.m_ready;
    assign push      = inflight_q;
    assign pending   = {2'b0, v0_q} + {2'b0, v1_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign room      = pending < 3'(FIFO_DEPTH);
    assign push_data = {canon(bus.mem_dout_b[WIDTH-1:0]), canon(bus.mem_dout_a[WIDTH-1:0])};
    assign unused_dout_hi = ^{bus.mem_dout_a[31:WIDTH], bus.mem_dout_b[31:WIDTH]};

    assign bus.m_valid = v0_q;
    assign bus.m_data  = data0_q;
    assign bus.m_index = idx0_q;
    assign bus.m_last  = last0_q;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        k_d     = issue ? k_q + 1'b1 : k_q;
        case (state_q)
            IDLE: begin
                k_d = '0;
                if (start_i)
                    state_d = RUN;
            end
            RUN:     if (issue && k_q == LAST_K) state_d = DRAIN;
            DRAIN:   if (!v0_q && !v1_q && !inflight_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The first RUN cycle only arms the reader, so reads begin one cycle after busy rises.
    always_comb begin
        busy_o          = (state_q != IDLE);
        done_o          = (state_q == DONE);
        issue           = (state_q == RUN) && arm_q && room;
        bus.mem_en      = issue;
        bus.mem_raddr_a = issue ? {k_q, 1'b0} : addr_a_q;
        bus.mem_raddr_b = issue ? {k_q, 1'b1} : addr_b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q         <= '0;
            arm_q       <= 1'b0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            inflight_q  <= 1'b0;
            infl_k_q    <= '0;
            infl_last_q <= 1'b0;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            data0_q     <= '0;
            data1_q     <= '0;
            idx0_q      <= '0;
            idx1_q      <= '0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
        end else begin
            k_q         <= k_d;
            arm_q       <= (state_q == RUN);
            inflight_q  <= issue;
            infl_k_q    <= k_q;
            infl_last_q <= (k_q == LAST_K);
            if (issue) begin
                addr_a_q <= {k_q, 1'b0};
                addr_b_q <= {k_q, 1'b1};
            end
            // Entry 0 is the head driving the stream; entry 1 only fills while the head is stalled.
            if (pop) begin
                if (v1_q) begin
                    data0_q <= data1_q;
                    idx0_q  <= idx1_q;
                    last0_q <= last1_q;
                    if (push) begin
                        data1_q <= push_data;
                        idx1_q  <= infl_k_q;
                        last1_q <= infl_last_q;
                    end else begin
                        v1_q <= 1'b0;
                    end
                end else if (push) begin
                    data0_q <= push_data;
                    idx0_q  <= infl_k_q;
                    last0_q <= infl_last_q;
                end else begin
                    v0_q <= 1'b0;
                end
            end else if (push) begin
                if (!v0_q) begin
                    data0_q <= push_data;
                    idx0_q  <= infl_k_q;
                    last0_q <= infl_last_q;
                    v0_q    <= 1'b1;
                end else begin
                    data1_q <= push_data;
                    idx1_q  <= infl_k_q;
                    last1_q <= infl_last_q;
                    v1_q    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ntt_coeff_unloader.sv
// Directed bench for ntt_coeff_unloader: streaming order and latency, canonicalization,
// random back-pressure, ignored restarts and reset behaviour against a behavioural BRAM.
module tb_ntt_coeff_unloader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] mem [0:255];

    ntt_coeff_unloader_if #(.WIDTH(16), .WIDTH_ADDR(8)) bus ();

    ntt_coeff_unloader #(
        .WIDTH(16), .WIDTH_ADDR(8), .N(256), .Q(3329), .FIFO_DEPTH(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .busy_o  (busy),
        .done_o  (done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // One-cycle-latency dual-port BRAM model.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            bus.mem_dout_a <= {16'h0000, mem[bus.mem_raddr_a]};
            bus.mem_dout_b <= {16'h0000, mem[bus.mem_raddr_b]};
        end
    end

    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic preload_ramp();
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        bus.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, bus.mem_en, bus.mem_raddr_a, bus.mem_raddr_b} !== 19'd0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %0h expected 0",
                     {busy, done, bus.mem_en, bus.mem_raddr_a, bus.mem_raddr_b});
        end
        checks++;
        if ({bus.m_valid, bus.m_data, bus.m_index, bus.m_last} !== 41'd0) begin
            errors++;
            $display("[TB] FAIL reset_stream: got %0h expected 0",
                     {bus.m_valid, bus.m_data, bus.m_index, bus.m_last});
        end
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        logic [31:0] exp;
        preload_ramp();
        bus.m_ready = 1'b1;
        applyStimulus();
        checks++;
        if ({busy, bus.mem_en, bus.m_valid} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL stream_t0: got %b expected 100", {busy, bus.mem_en, bus.m_valid});
        end
        @(negedge clk);
        checks++;
        if ({bus.mem_en, bus.mem_raddr_a, bus.mem_raddr_b} !== {1'b1, 8'd0, 8'd1}) begin
            errors++;
            $display("[TB] FAIL stream_first_read: got %0h expected %0h",
                     {bus.mem_en, bus.mem_raddr_a, bus.mem_raddr_b}, {1'b1, 8'd0, 8'd1});
        end
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stream_t2_valid: got %b expected 0", bus.m_valid);
        end
        @(negedge clk);
        for (int k = 0; k < 128; k++) begin
            exp = {16'(2 * k + 1), 16'(2 * k)};
            checks++;
            if ({bus.m_valid, bus.m_data, bus.m_index, bus.m_last} !== {1'b1, exp, 7'(k), k == 127}) begin
                errors++;
                $display("[TB] FAIL stream_beat%0d: got %0h expected %0h", k,
                         {bus.m_valid, bus.m_data, bus.m_index, bus.m_last},
                         {1'b1, exp, 7'(k), k == 127});
            end
            @(negedge clk);
        end
        checks++;
        if ({done, bus.m_valid, busy} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL stream_drain: got %b expected 001", {done, bus.m_valid, busy});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stream_done: got %b expected 1", done);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL stream_idle: got %b expected 00", {done, busy});
        end
    endtask

    task automatic test_canon();
        int n;
        logic [31:0] exp [0:2];
        exp[0] = {16'd0, 16'd3328};
        exp[1] = {16'd0, 16'd3328};
        exp[2] = {16'd3328, 16'd0};
        preload_ramp();
        mem[0] = 16'hFFFF;
        mem[1] = 16'd3329;
        mem[2] = 16'd6657;
        mem[3] = 16'd0;
        mem[4] = 16'hF2FF;
        mem[5] = 16'd3328;
        bus.m_ready = 1'b1;
        applyStimulus();
        n = 0;
        while (!bus.m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int b = 0; b < 3; b++) begin
            checks++;
            if ({bus.m_valid, bus.m_data} !== {1'b1, exp[b]}) begin
                errors++;
                $display("[TB] FAIL canon_beat%0d: got %0h expected %0h", b,
                         {bus.m_valid, bus.m_data}, {1'b1, exp[b]});
            end
            @(negedge clk);
        end
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL canon_finish: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_back_pressure();
        int k = 0, issued = 0, popped = 0, dones = 0, cycles = 0;
        logic prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
        logic [31:0] prev_data = '0;
        logic [6:0]  prev_idx = '0;
        preload_ramp();
        bus.m_ready = 1'b0;
        applyStimulus();
        while (!(k == 128 && !busy) && cycles < 3000) begin
            bus.m_ready = ($urandom_range(0, 99) < 30);
            #1;
            if (prev_valid && !prev_ready) begin
                checks++;
                if ({bus.m_valid, bus.m_data, bus.m_index, bus.m_last} !==
                    {1'b1, prev_data, prev_idx, prev_last}) begin
                    errors++;
                    $display("[TB] FAIL bp_stable: got %0h expected %0h",
                             {bus.m_valid, bus.m_data, bus.m_index, bus.m_last},
                             {1'b1, prev_data, prev_idx, prev_last});
                end
            end
            if (bus.mem_en) issued++;
            if (bus.m_valid && bus.m_ready) begin
                checks++;
                if ({bus.m_data, bus.m_index, bus.m_last} !==
                    {16'(2 * k + 1), 16'(2 * k), 7'(k), k == 127}) begin
                    errors++;
                    $display("[TB] FAIL bp_beat%0d: got %0h expected %0h", k,
                             {bus.m_data, bus.m_index, bus.m_last},
                             {16'(2 * k + 1), 16'(2 * k), 7'(k), k == 127});
                end
                k++;
                popped++;
            end
            checks++;
            if (issued - popped > 2) begin
                errors++;
                $display("[TB] FAIL bp_overflow: got %0d outstanding expected <= 2", issued - popped);
            end
            if (done) dones++;
            prev_valid = bus.m_valid;
            prev_ready = bus.m_ready;
            prev_data  = bus.m_data;
            prev_idx   = bus.m_index;
            prev_last  = bus.m_last;
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (k != 128 || cycles >= 3000) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d beats in %0d cycles expected 128", k, cycles);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("[TB] FAIL bp_done: got %0d pulses expected 1", dones);
        end
        bus.m_ready = 1'b1;
    endtask

    task automatic test_restart();
        int beats = 0, dones = 0, cycles = 0;
        preload_ramp();
        bus.m_ready = 1'b1;
        applyStimulus();
        while (busy && cycles < 400) begin
            start = bus.m_valid && (bus.m_index == 7'd5 || bus.m_index == 7'd127);
            if (bus.m_valid) begin
                checks++;
                if (bus.m_index !== 7'(beats)) begin
                    errors++;
                    $display("[TB] FAIL restart_index: got %0d expected %0d", bus.m_index, beats);
                end
                beats++;
            end
            if (done) dones++;
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        checks++;
        if (beats != 128 || dones != 1) begin
            errors++;
            $display("[TB] FAIL restart_count: got %0d beats %0d done expected 128 beats 1 done",
                     beats, dones);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_idle: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_reset_midstream();
        int n = 0;
        preload_ramp();
        bus.m_ready = 1'b1;
        applyStimulus();
        while (!(bus.m_valid && bus.m_index == 7'd40) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({bus.m_valid, bus.m_index} !== {1'b1, 7'd40}) begin
            errors++;
            $display("[TB] FAIL midrst_reach: got %0h expected %0h", {bus.m_valid, bus.m_index},
                     {1'b1, 7'd40});
        end
        bus.m_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, bus.mem_en, bus.mem_raddr_a, bus.mem_raddr_b} !== 19'd0) begin
            errors++;
            $display("[TB] FAIL midrst_ctrl: got %0h expected 0",
                     {busy, done, bus.mem_en, bus.mem_raddr_a, bus.mem_raddr_b});
        end
        checks++;
        if ({bus.m_valid, bus.m_data, bus.m_index, bus.m_last} !== 41'd0) begin
            errors++;
            $display("[TB] FAIL midrst_stream: got %0h expected 0",
                     {bus.m_valid, bus.m_data, bus.m_index, bus.m_last});
        end
        @(negedge clk);
        checks++;
        if ({busy, bus.m_valid} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL midrst_idle: got %b expected 00", {busy, bus.m_valid});
        end
        bus.m_ready = 1'b1;
        applyStimulus();
        n = 0;
        while (!bus.m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({bus.m_valid, bus.m_data, bus.m_index} !== {1'b1, 32'h0001_0000, 7'd0}) begin
            errors++;
            $display("[TB] FAIL midrst_restart: got %0h expected %0h",
                     {bus.m_valid, bus.m_data, bus.m_index}, {1'b1, 32'h0001_0000, 7'd0});
        end
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_finish: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_reset_with_start();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_start_busy: got %b expected 0", busy);
        end
        @(negedge clk);
        checks++;
        if ({busy, bus.mem_en, bus.m_valid} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL rst_start_idle: got %b expected 000", {busy, bus.mem_en, bus.m_valid});
        end
    endtask

    initial begin
        bus.m_ready    = 1'b0;
        bus.mem_dout_a = '0;
        bus.mem_dout_b = '0;
        rst            = 1'b1;
        start          = 1'b0;
        test_reset();
        test_streaming();
        test_canon();
        test_back_pressure();
        test_restart();
        test_reset_midstream();
        test_reset_with_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/ntt_coeff_unloader.md
Name: ntt_coeff_unloader

Overview:
- Read-out side of the NTT coefficient BRAM: after the NTT/INTT engine signals completion, this block reads all 256 coefficients through both BRAM read ports.
- Each coefficient is canonicalized to [0, Q), and the pairs are streamed out on a valid/ready interface, two coefficients per beat, in natural index order.
- The block sits between the coefficient BRAM and the downstream encode/compress logic. It owns the BRAM read ports only while busy.

Parameters:
WIDTH, 16, coefficient width in bits
WIDTH_ADDR, 8, BRAM address width
N, 256, coefficients per polynomial (must be even)
Q, 3329, modulus used for canonicalization
FIFO_DEPTH, 2, output buffer entries

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse: begin unloading; ignored while busy
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the final beat handshake
mem_en  output  1  BRAM read enable (both ports)
mem_raddr_a  output  WIDTH_ADDR  port A read address (even index 2k)
mem_raddr_b  output  WIDTH_ADDR  port B read address (odd index 2k+1)
mem_dout_a  input  32  port A read data; low WIDTH bits used; valid one cycle after mem_en
mem_dout_b  input  32  port B read data; low WIDTH bits used
m_valid  output  1  output beat valid
m_ready  input  1  downstream accepts beat
m_data  output  2*WIDTH  {coef[2k+1], coef[2k]}, each in [0, Q)
m_index  output  WIDTH_ADDR-1  beat index k (0..N/2-1)
m_last  output  1  high with beat k = N/2-1

Behaviour:
- Reset (rst=1 at a clock edge) returns the block to IDLE and empties the FIFO. All outputs are 0: busy, done, mem_en, mem_raddr_a, mem_raddr_b, m_valid, m_data, m_index, m_last. In-flight reads are discarded. Reset overrides start in the same cycle.
- States:
  - IDLE: go to RUN when start=1; rd_ptr=0.
  - RUN: issue reads. Go to DRAIN after the read for k=N/2-1 is issued.
  - DRAIN: no reads are issued. Go to DONE when the FIFO is empty, nothing is in flight, and the last beat has handshaken.
  - DONE: done=1 for one cycle, then IDLE.
- busy = (state != IDLE). A start pulse in any state other than IDLE has no effect.
- Read issue in RUN:
  - Condition: occupancy + in_flight − (m_valid & m_ready) < FIFO_DEPTH.
  - When the condition holds: mem_en=1, mem_raddr_a=2k, mem_raddr_b=2k+1, k increments.
  - Otherwise mem_en=0 and the addresses hold their value.
  - in_flight is 1 in the cycle after a read is issued.
- Read latency is 1 cycle. The returned data is canonicalized combinationally and written into the FIFO together with k and the last flag.
- Canonicalization:
  - Input is a signed WIDTH-bit value x with a legal range of [−Q, 2Q).
  - If x<0, the result is x+Q. If x≥Q, the result is x−Q. Otherwise the result is x.
  - Output is an unsigned WIDTH-bit value.
  - Out-of-range input is undefined, but must not hang the FSM.
- FIFO:
  - The head entry drives m_data, m_index and m_last; these outputs are registered.
  - Simultaneous push and pop in the same cycle is legal; occupancy stays unchanged.
  - Overflow is impossible by the issue rule. The bench asserts it never happens.
- Handshake:
  - Once m_valid=1, m_valid, m_data, m_index and m_last stay stable until m_ready=1.
  - m_valid does not depend combinationally on m_ready.
- Latency, for a start sampled at edge T:
  - mem_en=1 during the cycle after T+1.
  - The first beat is m_valid=1 after edge T+3.
  - With m_ready held at 1, one beat per cycle, no bubbles: 128 consecutive beats.
  - done is high after the edge that follows the last handshake.
- rd_ptr does not wrap: N/2 reads are issued in total.
- Once m_valid=1, m_data holds canonical values only.

Test Plan:
- BRAM preloaded with coef[i]=i, m_ready=1, start pulse → m_valid rises 3 edges after start. 128 consecutive beats; beat k m_data={2k+1, 2k}. m_last only at k=127. done pulses once, then busy=0.
- Canonicalization: preload coef[0]=−1, coef[1]=3329, coef[2]=6657, coef[3]=0, coef[4]=−3329, coef[5]=3328 → beat0={0, 3328}, beat1={0, 3328}, beat2={3328, 0}.
- Random m_ready at 30% duty → every beat is delivered exactly once, in order; outputs stay stable while stalled; FIFO never overflows; mem_en is 0 whenever occupancy + in_flight would exceed 2.
- start re-pulsed at beats 5 and 127 → ignored; exactly 128 beats and one done pulse.
- rst=1 at beat 40 while m_valid=1 and m_ready=0 → next cycle all outputs are 0 and state is IDLE. A following start streams from k=0 with no stale beat.
- rst=1 and start=1 in the same cycle → stays IDLE, busy=0.
